// File: rtl/spi_regbank.sv
// Register bank driven by strobes from an SPI slave in another clock domain.
// Strobes are synchronised and edge-detected into single-cycle enables for write and read.
module spi_regbank #(
  parameter int         DSZ         = 8,
  parameter int         NREGS       = 4,
  parameter logic [6:0] BASE_ADDR   = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_we,
  input  logic                   spi_re,
  input  logic [6:0]             addr,
  input  logic [DSZ-1:0]         wdat,
  output logic [DSZ-1:0]         rdat,
  output logic [NREGS*DSZ-1:0]   regs,
  output logic [DSZ-1:0]         rd_count,
  output logic [DSZ-1:0]         wr_count,
  output logic                   bad_addr
);

  localparam logic [6:0]     CTRL_ADDR = BASE_ADDR - 7'd1;
  localparam logic [6:0]     RDC_ADDR  = BASE_ADDR - 7'd2;
  localparam logic [6:0]     WRC_ADDR  = BASE_ADDR - 7'd3;
  localparam logic [DSZ-1:0] ONE       = {{(DSZ-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
  logic [SYNC_STAGES-1:0] re_sync_q, re_sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   we_prev_q, we_prev_d;
  logic                   re_prev_q, re_prev_d;
  logic                   we_armed_q, we_armed_d;
  logic                   re_armed_q, re_armed_d;
  logic                   we_en_q, we_en_d;
  logic                   re_en_q, re_en_d;
  logic                   we_last, re_last, vld_last;

  assign we_last  = we_sync_q[SYNC_STAGES-1];
  assign re_last  = re_sync_q[SYNC_STAGES-1];
  assign vld_last = vld_q[SYNC_STAGES-1];

  // vld tracks when the synchroniser holds a real post-reset sample; a strobe
  // must be seen low after that before its rising edge is accepted.
  always_comb begin
    we_sync_d  = {we_sync_q[SYNC_STAGES-2:0], spi_we};
    re_sync_d  = {re_sync_q[SYNC_STAGES-2:0], spi_re};
    vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
    we_prev_d  = we_last;
    re_prev_d  = re_last;
    we_armed_d = we_armed_q | (vld_last & ~we_last);
    re_armed_d = re_armed_q | (vld_last & ~re_last);
    we_en_d    = we_last & ~we_prev_q & we_armed_q;
    re_en_d    = re_last & ~re_prev_q & re_armed_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_sync_q  <= '0;
      re_sync_q  <= '0;
      vld_q      <= '0;
      we_prev_q  <= 1'b0;
      re_prev_q  <= 1'b0;
      we_armed_q <= 1'b0;
      re_armed_q <= 1'b0;
      we_en_q    <= 1'b0;
      re_en_q    <= 1'b0;
    end else begin
      we_sync_q  <= we_sync_d;
      re_sync_q  <= re_sync_d;
      vld_q      <= vld_d;
      we_prev_q  <= we_prev_d;
      re_prev_q  <= re_prev_d;
      we_armed_q <= we_armed_d;
      re_armed_q <= re_armed_d;
      we_en_q    <= we_en_d;
      re_en_q    <= re_en_d;
    end
  end

  // Address decode; 8-bit offset avoids wrap when the bank sits near 7'h7F.
  logic [7:0]     offs;
  logic           is_gen;
  logic [DSZ-1:0] rd_sel;

  assign offs   = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign is_gen = (addr >= BASE_ADDR) && (offs < 8'(NREGS));

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DSZ-1:0] reg_q, reg_d;

      always_comb begin
        reg_d = reg_q;
        if (we_en_q && is_gen && offs == 8'(gi)) reg_d = wdat;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) reg_q <= '0;
        else        reg_q <= reg_d;
      end

      assign regs[gi*DSZ +: DSZ] = reg_q;
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (is_gen && offs == 8'(i)) rd_sel = regs[i*DSZ +: DSZ];
    end
  end

  logic [DSZ-1:0] rdat_q, rdat_d;
  logic [DSZ-1:0] rd_cnt_q, rd_cnt_d;
  logic [DSZ-1:0] wr_cnt_q, wr_cnt_d;
  logic           bad_q, bad_d;
  logic           clr;

  assign clr = we_en_q && (addr == CTRL_ADDR) && wdat[0];

  // Counter registers are read-only, so writes to them count as unmapped.
  always_comb begin
    rdat_d   = rdat_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    bad_d    = bad_q;
    if (we_en_q) begin
      if (is_gen) begin
        wr_cnt_d = wr_cnt_q + ONE;
      end else if (addr == CTRL_ADDR) begin
        if (wdat[0]) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          bad_d    = 1'b0;
        end else begin
          wr_cnt_d = wr_cnt_q + ONE;
        end
      end else begin
        bad_d = 1'b1;
      end
    end
    if (re_en_q) begin
      if (is_gen)                rdat_d = rd_sel;
      else if (addr == RDC_ADDR) rdat_d = rd_cnt_q;
      else if (addr == WRC_ADDR) rdat_d = wr_cnt_q;
      else begin
        rdat_d = '0;
        bad_d  = 1'b1;
      end
      if (!clr) rd_cnt_d = rd_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdat_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      rdat_q   <= rdat_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      bad_q    <= bad_d;
    end
  end

  assign rdat     = rdat_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
  assign bad_addr = bad_q;

endmodule
